// File: rtl/cram_st_seq_ctrl_if.sv
// Port bundle between the CRAM input port and the store-sequence controller.
interface cram_st_seq_ctrl_if #(
  parameter int unsigned WIDTH_LENGTH = 8,
  parameter int unsigned NUM_IDS      = 2
);
  localparam int unsigned IdW = $clog2(NUM_IDS + 1);

  logic                    I_Valid;
  logic                    I_Nack;
  logic                    is_Acq;
  logic                    is_Rls;
  logic                    is_RConfigData;
  logic                    is_AuxData;
  logic                    is_AccessEnd;
  logic [WIDTH_LENGTH-1:0] I_Length;

  logic                    O_Set_ConfigData;
  logic                    O_We_Length;
  logic                    O_We_Stride;
  logic                    O_We_Base;
  logic                    O_Req;
  logic                    O_Acq;
  logic                    O_Rls;
  logic                    O_Trm;
  logic [IdW-1:0]          O_IDNo;
  logic                    O_StoreIDs;
  logic                    O_Busy;

  modport master (
    output I_Valid, I_Nack, is_Acq, is_Rls, is_RConfigData, is_AuxData, is_AccessEnd, I_Length,
    input  O_Set_ConfigData, O_We_Length, O_We_Stride, O_We_Base, O_Req, O_Acq, O_Rls, O_Trm,
           O_IDNo, O_StoreIDs, O_Busy
  );

  modport slave (
    input  I_Valid, I_Nack, is_Acq, is_Rls, is_RConfigData, is_AuxData, is_AccessEnd, I_Length,
    output O_Set_ConfigData, O_We_Length, O_We_Stride, O_We_Base, O_Req, O_Acq, O_Rls, O_Trm,
           O_IDNo, O_StoreIDs, O_Busy
  );
endinterface

// File: rtl/cram_st_seq_ctrl.sv
// CRAM store-sequence controller: parses ID header, attribute and R-config
// blocks, then issues registered store requests with first/last-word tokens.
module cram_st_seq_ctrl #(
  parameter int unsigned WIDTH_LENGTH   = 8,
  parameter int unsigned NUM_IDS        = 2,
  parameter int unsigned NumWordsLength = 1,
  parameter int unsigned NumWordsStride = 1,
  parameter int unsigned NumWordsBase   = 1,
  parameter bit          EXTERN         = 1'b0
) (
  input logic              clock,
  input logic              reset,
  cram_st_seq_ctrl_if.slave bus
);

  localparam int unsigned IdW   = $clog2(NUM_IDS + 1);
  localparam int unsigned MaxLs = (NumWordsLength > NumWordsStride) ? NumWordsLength : NumWordsStride;
  localparam int unsigned MaxFw = (MaxLs > NumWordsBase) ? MaxLs : NumWordsBase;
  localparam int unsigned FwW   = (MaxFw > 1) ? $clog2(MaxFw) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_GET_ATTRIB, S_GET_CONFIG, S_GET_ATTRIB2, S_READY, S_ACTIVE
  } state_e;

  typedef enum logic [1:0] {F_CFG, F_LEN, F_STR, F_BASE} field_e;

  state_e                  state_q;
  field_e                  field_q;
  logic [FwW-1:0]          fw_cnt_q;
  logic [IdW-1:0]          c_id_q;
  logic [WIDTH_LENGTH-1:0] st_cnt_q;
  logic [WIDTH_LENGTH-1:0] st_cnt_d;
  logic                    r_req_q;
  logic                    r_acq_q;
  logic                    r_last_q;

  logic store_ids_c;
  logic set_cfg_c;
  logic we_len_c;
  logic we_str_c;
  logic we_base_c;
  logic len_hit_c;

  // Accept strobes for header/config words; field counter counts words already taken.
  always_comb begin
    store_ids_c = 1'b0;
    set_cfg_c   = 1'b0;
    we_len_c    = 1'b0;
    we_str_c    = 1'b0;
    we_base_c   = 1'b0;
    if (c_id_q == '0) store_ids_c = bus.is_Acq;
    else              store_ids_c = bus.I_Valid;
    if ((state_q == S_GET_CONFIG) && bus.I_Valid) begin
      case (field_q)
        F_CFG:   set_cfg_c = 1'b1;
        F_LEN:   we_len_c  = (fw_cnt_q == FwW'(NumWordsLength - 1));
        F_STR:   we_str_c  = (fw_cnt_q == FwW'(NumWordsStride - 1));
        F_BASE:  we_base_c = (fw_cnt_q == FwW'(NumWordsBase - 1));
        default: ;
      endcase
    end
  end

  // Store counter saturates instead of wrapping (matters for unbounded length).
  always_comb begin
    st_cnt_d  = (st_cnt_q == '1) ? st_cnt_q : st_cnt_q + WIDTH_LENGTH'(1);
    len_hit_c = (bus.I_Length != '0) && (st_cnt_q == bus.I_Length - WIDTH_LENGTH'(1));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      c_id_q <= '0;
    end else if (store_ids_c) begin
      c_id_q <= (c_id_q == IdW'(NUM_IDS)) ? '0 : c_id_q + IdW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      field_q  <= F_CFG;
      fw_cnt_q <= '0;
      st_cnt_q <= '0;
      r_req_q  <= 1'b0;
      r_acq_q  <= 1'b0;
      r_last_q <= 1'b0;
    end else begin
      r_req_q  <= 1'b0;
      r_acq_q  <= 1'b0;
      r_last_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          st_cnt_q <= '0;
          if ((c_id_q == IdW'(NUM_IDS)) && bus.I_Valid) state_q <= S_GET_ATTRIB;
        end
        S_GET_ATTRIB: begin
          if (bus.I_Valid && bus.is_RConfigData) state_q <= S_GET_CONFIG;
        end
        S_GET_CONFIG: begin
          if (bus.I_Valid) begin
            case (field_q)
              F_CFG: begin
                field_q  <= F_LEN;
                fw_cnt_q <= '0;
              end
              F_LEN: begin
                if (we_len_c) begin
                  field_q  <= F_STR;
                  fw_cnt_q <= '0;
                end else fw_cnt_q <= fw_cnt_q + FwW'(1);
              end
              F_STR: begin
                if (we_str_c) begin
                  field_q  <= F_BASE;
                  fw_cnt_q <= '0;
                end else fw_cnt_q <= fw_cnt_q + FwW'(1);
              end
              F_BASE: begin
                if (we_base_c) begin
                  field_q  <= F_CFG;
                  fw_cnt_q <= '0;
                  state_q  <= S_GET_ATTRIB2;
                end else fw_cnt_q <= fw_cnt_q + FwW'(1);
              end
              default: field_q <= F_CFG;
            endcase
          end
        end
        S_GET_ATTRIB2: begin
          if (bus.I_Valid && !bus.I_Nack && bus.is_AuxData) begin
            state_q <= S_ACTIVE;
            r_req_q <= EXTERN;
          end else if (!bus.I_Valid && !bus.I_Nack) begin
            state_q <= S_READY;
          end
        end
        S_READY: begin
          if (bus.I_Valid) state_q <= S_ACTIVE;
        end
        S_ACTIVE: begin
          // Release and external end take priority over stall and data.
          if (bus.is_Rls || bus.is_AccessEnd) begin
            state_q  <= S_IDLE;
            st_cnt_q <= '0;
          end else if (!bus.I_Nack && bus.I_Valid) begin
            r_req_q  <= 1'b1;
            st_cnt_q <= st_cnt_d;
            r_acq_q  <= (st_cnt_q == '0);
            if (len_hit_c) begin
              r_last_q <= 1'b1;
              state_q  <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Input-driven outputs are masked while reset is held.
  assign bus.O_StoreIDs       = store_ids_c & ~reset;
  assign bus.O_Set_ConfigData = set_cfg_c & ~reset;
  assign bus.O_We_Length      = we_len_c & ~reset;
  assign bus.O_We_Stride      = we_str_c & ~reset;
  assign bus.O_We_Base        = we_base_c & ~reset;
  assign bus.O_IDNo           = c_id_q;
  assign bus.O_Req            = r_req_q;
  assign bus.O_Acq            = r_acq_q;
  assign bus.O_Rls            = r_last_q | (bus.is_Rls & (state_q != S_IDLE) & ~reset);
  assign bus.O_Trm            = r_last_q | ((bus.is_AccessEnd | (bus.is_Rls & (state_q == S_ACTIVE))) & ~reset);
  assign bus.O_Busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_cram_st_seq_ctrl.sv
// Directed bench for cram_st_seq_ctrl: vector table for a full sequence plus
// hand-written stall, unbounded-length, access-end and reset sequences.
module tb_cram_st_seq_ctrl;
  localparam int unsigned WL  = 8;
  localparam int unsigned NI  = 2;
  localparam int unsigned NV  = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cram_st_seq_ctrl_if #(.WIDTH_LENGTH(WL), .NUM_IDS(NI)) bus ();

  cram_st_seq_ctrl #(
    .WIDTH_LENGTH(WL), .NUM_IDS(NI), .NumWordsLength(2), .NumWordsStride(1),
    .NumWordsBase(2), .EXTERN(1'b0)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  // Inputs {v,n,acq,rls,rcfg,aux,aend}; outputs {sid,idno[1:0],cfg,wl,ws,wb,req,acq,rls,trm,busy}
  typedef struct {
    logic [6:0]    in;
    logic [WL-1:0] len;
    logic [11:0]   exp;
  } vec_t;

  vec_t tbl [NV];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(logic [6:0] in, logic [WL-1:0] len, logic [11:0] e);
    vec_t r;
    r.in = in; r.len = len; r.exp = e;
    return r;
  endfunction

  function automatic logic [11:0] outs();
    return {bus.O_StoreIDs, bus.O_IDNo, bus.O_Set_ConfigData, bus.O_We_Length,
            bus.O_We_Stride, bus.O_We_Base, bus.O_Req, bus.O_Acq, bus.O_Rls,
            bus.O_Trm, bus.O_Busy};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic [6:0] in, input logic [WL-1:0] len);
    {bus.I_Valid, bus.I_Nack, bus.is_Acq, bus.is_Rls, bus.is_RConfigData,
     bus.is_AuxData, bus.is_AccessEnd} = in;
    bus.I_Length = len;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(7'b0, '0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Header + config block, ending in ACTIVE; via_aux selects the aux-data entry.
  task automatic goto_active(input bit via_aux, input logic [WL-1:0] len);
    drive(7'b1010000, len); tick();
    drive(7'b1000000, len); tick();
    drive(7'b1000000, len); tick();
    drive(7'b1000100, len); tick();
    for (int i = 0; i < 6; i++) begin
      drive(7'b1000000, len); tick();
    end
    if (via_aux) begin
      drive(7'b1000010, len); tick();
    end else begin
      drive(7'b0000000, len); tick();
      drive(7'b1000000, len); tick();
    end
    drive(7'b0000000, len);
  endtask

  initial begin
    logic [11:0] o;
    logic [8:0]  b_req;
    int          reqs;
    int          acqs;
    int          early;

    tbl[0]  = mk(7'b0000000, 8'd4, 12'b0_00_0000_0000_0);
    tbl[1]  = mk(7'b1010000, 8'd4, 12'b1_00_0000_0000_0);
    tbl[2]  = mk(7'b1000000, 8'd4, 12'b1_01_0000_0000_0);
    tbl[3]  = mk(7'b1000000, 8'd4, 12'b1_10_0000_0000_0);
    tbl[4]  = mk(7'b0000000, 8'd4, 12'b0_00_0000_0000_1);
    tbl[5]  = mk(7'b1000100, 8'd4, 12'b0_00_0000_0000_1);
    tbl[6]  = mk(7'b1000000, 8'd4, 12'b0_00_1000_0000_1);
    tbl[7]  = mk(7'b1000000, 8'd4, 12'b0_00_0000_0000_1);
    tbl[8]  = mk(7'b1000000, 8'd4, 12'b0_00_0100_0000_1);
    tbl[9]  = mk(7'b1000000, 8'd4, 12'b0_00_0010_0000_1);
    tbl[10] = mk(7'b1000000, 8'd4, 12'b0_00_0000_0000_1);
    tbl[11] = mk(7'b1000000, 8'd4, 12'b0_00_0001_0000_1);
    tbl[12] = mk(7'b0000000, 8'd4, 12'b0_00_0000_0000_1);
    tbl[13] = mk(7'b1000000, 8'd4, 12'b0_00_0000_0000_1);
    tbl[14] = mk(7'b1000000, 8'd4, 12'b0_00_0000_0000_1);
    tbl[15] = mk(7'b1000000, 8'd4, 12'b0_00_0000_1100_1);
    tbl[16] = mk(7'b1000000, 8'd4, 12'b0_00_0000_1000_1);
    tbl[17] = mk(7'b1000000, 8'd4, 12'b0_00_0000_1000_1);
    tbl[18] = mk(7'b1010000, 8'd4, 12'b1_00_0000_1011_0);
    tbl[19] = mk(7'b0000000, 8'd4, 12'b0_01_0000_0000_0);

    do_reset();

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].in, tbl[i].len);
      sample();
      o = outs();
      chk($sformatf("vec%0d", i), 32'(o), 32'(tbl[i].exp));
      tick();
    end

    // Stall on word 2 for three cycles, aux-data entry (no request when not external).
    do_reset();
    goto_active(1'b1, 8'd4);
    b_req = 9'b0_1110_0010;
    reqs  = 0;
    for (int i = 0; i < 9; i++) begin
      case (i)
        0, 4, 5, 6: drive(7'b1000000, 8'd4);
        1, 2, 3:    drive(7'b1100000, 8'd4);
        default:    drive(7'b0000000, 8'd4);
      endcase
      sample();
      chk($sformatf("nack_req%0d", i), 32'(bus.O_Req), 32'(b_req[i]));
      if (bus.O_Req) reqs++;
      if (i == 7) begin
        chk("nack_rls", 32'(bus.O_Rls), 32'd1);
        chk("nack_trm", 32'(bus.O_Trm), 32'd1);
        chk("nack_busy", 32'(bus.O_Busy), 32'd0);
      end
      tick();
    end
    chk("nack_req_count", 32'(reqs), 32'd4);

    // Unbounded length: 300 words then release; counter saturates, no auto-stop.
    do_reset();
    goto_active(1'b0, 8'd0);
    reqs = 0; acqs = 0; early = 0;
    for (int i = 0; i < 300; i++) begin
      drive(7'b1000000, 8'd0);
      sample();
      if (bus.O_Req) reqs++;
      if (bus.O_Acq) acqs++;
      if (bus.O_Rls || bus.O_Trm || !bus.O_Busy) early++;
      tick();
    end
    drive(7'b1001000, 8'd0);
    sample();
    if (bus.O_Req) reqs++;
    chk("unb_rls", 32'(bus.O_Rls), 32'd1);
    chk("unb_trm", 32'(bus.O_Trm), 32'd1);
    tick();
    drive(7'b0000000, 8'd0);
    sample();
    if (bus.O_Req) reqs++;
    chk("unb_busy_after", 32'(bus.O_Busy), 32'd0);
    chk("unb_req_count", 32'(reqs), 32'd300);
    chk("unb_acq_count", 32'(acqs), 32'd1);
    chk("unb_early_term", 32'(early), 32'd0);
    tick();

    // External access end terminates without a release token.
    goto_active(1'b0, 8'd4);
    drive(7'b1000001, 8'd4);
    sample();
    chk("aend_trm_rls", 32'({bus.O_Trm, bus.O_Rls}), 32'b10);
    tick();
    drive(7'b0000000, 8'd4);
    sample();
    chk("aend_busy_req", 32'({bus.O_Busy, bus.O_Req}), 32'b00);
    tick();

    // Reset after two of four data words aborts cleanly.
    goto_active(1'b0, 8'd4);
    drive(7'b1000000, 8'd4); tick();
    drive(7'b1000000, 8'd4); tick();
    rst = 1'b1;
    drive(7'b1000000, 8'd4); tick();
    rst = 1'b0;
    drive(7'b0000000, 8'd4);
    sample();
    o = outs();
    chk("rst_outs", 32'(o), 32'd0);
    tick();
    drive(7'b1010000, 8'd4);
    sample();
    chk("rst_restart", 32'({bus.O_StoreIDs, bus.O_IDNo}), 32'b100);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
